// File: rtl/in_reg_cfg_ctrl.sv
// in_reg_cfg_ctrl: serial configuration controller for a bank of input-register cells.
// One config word is accepted per handshake. The controller shifts it into the chain
// LSB-first and captures the old chain contents as readback. It then pulses the cells'
// shadow latch and holds the cell data registers in clear for CLR_CYCLES cycles.
module in_reg_cfg_ctrl #(
  parameter int NUM_CELLS     = 8,
  parameter int BITS_PER_CELL = 2,
  parameter int CLR_CYCLES    = 2,
  localparam int TOTAL        = NUM_CELLS * BITS_PER_CELL
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [TOTAL-1:0] cfg_data,
  output logic             sc_en,
  output logic             sc_data,
  input  logic             sc_ret,
  output logic             sc_latch,
  output logic             cells_clr,
  output logic             busy,
  output logic             done,
  output logic [TOTAL-1:0] rb_data
);

  // The counter is shared between the shift phase and the clear phase, so it must
  // be wide enough for whichever of the two runs longer.
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int CLW   = $clog2(CLR_CYCLES + 1);
  localparam int CNT_W = (CW > CLW) ? CW : CLW;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'((CLR_CYCLES > 0) ? CLR_CYCLES - 1 : 0);
  localparam bit               SKIP_CLR   = (CLR_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOTAL-1:0]   shreg_q, shreg_d;
  logic [TOTAL-1:0]   rb_q, rb_d;
  logic               done_q, done_d;
  logic [TOTAL-1:0]   shreg_shifted;

  // The chain tail enters at the MSB, so after TOTAL shifts the returned bit j sits at j.
  generate
    if (TOTAL == 1) begin : g_shift_one
      assign shreg_shifted = sc_ret;
    end else begin : g_shift_many
      assign shreg_shifted = {sc_ret, shreg_q[TOTAL-1:1]};
    end
  endgenerate

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge IQC) begin
    if (QRT) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic for IDLE -> SHIFT -> LATCH -> (CLEAR) -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == SHIFT_LAST) state_d = ST_LATCH;
      ST_LATCH: state_d = SKIP_CLR ? ST_IDLE : ST_CLEAR;
      ST_CLEAR: if (cnt_q == CLR_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: counter, shift register, readback capture and done pulse.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    rb_d    = rb_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          shreg_d = cfg_data;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg_shifted;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_LATCH: begin
        rb_d   = shreg_q;
        cnt_d  = '0;
        done_d = SKIP_CLR;
      end
      ST_CLEAR: begin
        cnt_d  = cnt_q + CNT_W'(1);
        done_d = (cnt_q == CLR_LAST);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge IQC) begin
    if (QRT) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      rb_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      rb_q    <= rb_d;
      done_q  <= done_d;
    end
  end

  // Outputs decoded purely from registered state; sc_data is gated so it idles low.
  always_comb begin
    cfg_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    sc_en     = (state_q == ST_SHIFT);
    sc_data   = (state_q == ST_SHIFT) & shreg_q[0];
    sc_latch  = (state_q == ST_LATCH);
    cells_clr = (state_q == ST_CLEAR);
    done      = done_q;
    rb_data   = rb_q;
  end

endmodule

// File: tb/tb_in_reg_cfg_ctrl.sv
// Bench for in_reg_cfg_ctrl: two instances (CLR_CYCLES=2 and CLR_CYCLES=0), each
// attached to a behavioural shift-register chain with a shadow latch.
module tb_in_reg_cfg_ctrl;
  localparam int T    = 16;
  localparam int CLR  = 2;
  localparam int LAST = T + 2 + CLR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  // Instance A (CLR_CYCLES=2)
  logic         a_valid, a_ready, a_sc_en, a_sc_data, a_sc_ret, a_latch, a_clr, a_busy, a_done;
  logic [T-1:0] a_data, a_rb;
  // Instance B (CLR_CYCLES=0)
  logic         b_valid, b_ready, b_sc_en, b_sc_data, b_sc_ret, b_latch, b_clr, b_busy, b_done;
  logic [T-1:0] b_data, b_rb;

  in_reg_cfg_ctrl #(.NUM_CELLS(8), .BITS_PER_CELL(2), .CLR_CYCLES(CLR)) u_dut_a (
    .IQC(clk), .QRT(rst), .cfg_valid(a_valid), .cfg_ready(a_ready), .cfg_data(a_data),
    .sc_en(a_sc_en), .sc_data(a_sc_data), .sc_ret(a_sc_ret), .sc_latch(a_latch),
    .cells_clr(a_clr), .busy(a_busy), .done(a_done), .rb_data(a_rb)
  );

  in_reg_cfg_ctrl #(.NUM_CELLS(8), .BITS_PER_CELL(2), .CLR_CYCLES(0)) u_dut_b (
    .IQC(clk), .QRT(rst), .cfg_valid(b_valid), .cfg_ready(b_ready), .cfg_data(b_data),
    .sc_en(b_sc_en), .sc_data(b_sc_data), .sc_ret(b_sc_ret), .sc_latch(b_latch),
    .cells_clr(b_clr), .busy(b_busy), .done(b_done), .rb_data(b_rb)
  );

  // Chain models: serial in at the MSB end, tail at bit 0, shadow latch copies the chain.
  logic         pre;
  logic [T-1:0] pre_val;
  logic [T-1:0] chain_a, active_a, chain_b, active_b;
  int           a_latch_cnt;
  logic         b_clr_seen;

  assign a_sc_ret = chain_a[0];
  assign b_sc_ret = chain_b[0];

  always @(posedge clk) begin
    if (pre) begin
      chain_a     <= pre_val;
      chain_b     <= pre_val;
      active_a    <= '0;
      active_b    <= '0;
      a_latch_cnt <= 0;
      b_clr_seen  <= 1'b0;
    end else begin
      if (a_sc_en)  chain_a  <= {a_sc_data, chain_a[T-1:1]};
      if (a_latch)  active_a <= chain_a;
      if (b_sc_en)  chain_b  <= {b_sc_data, chain_b[T-1:1]};
      if (b_latch)  active_b <= chain_b;
      if (a_latch)  a_latch_cnt <= a_latch_cnt + 1;
      if (b_clr)    b_clr_seen  <= 1'b1;
    end
  end

  typedef struct {
    logic [T-1:0] data;
    logic [T-1:0] exp_rb;
    logic [T-1:0] exp_active;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] outs_a();
    return {a_ready, a_busy, a_sc_en, a_sc_data, a_latch, a_clr, a_done};
  endfunction

  function automatic logic [6:0] outs_b();
    return {b_ready, b_busy, b_sc_en, b_sc_data, b_latch, b_clr, b_done};
  endfunction

  // Runs one full sequence on A. Caller has presented valid/data at a negedge with A idle.
  task automatic seq_a(input logic [T-1:0] w, input logic [T-1:0] exp_rb,
                       input bit hold, input logic [T-1:0] nxt, input bit glitch);
    logic [6:0] e;
    chk("a_start_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    for (int c = 1; c <= LAST; c++) begin
      @(negedge clk);
      e = {c == LAST, c != LAST, c <= T, (c <= T) ? w[(c-1) % T] : 1'b0,
           c == T + 1, (c >= T + 2) && (c <= T + 1 + CLR), c == LAST};
      chk($sformatf("a_outs_c%0d", c), 32'(outs_a()), 32'(e));
      if (c == 1) begin
        if (hold) a_data = nxt;
        else      a_valid = 1'b0;
      end
      if (glitch && c == 3) begin a_valid = 1'b1; a_data = '1; end
      if (glitch && c == 4) begin a_valid = 1'b0; a_data = w;  end
    end
    chk("a_rb_data", 32'(a_rb), 32'(exp_rb));
    chk("a_active", 32'(active_a), 32'(w));
    $display("seq A word=%h rb=%h active=%h", w, a_rb, active_a);
  endtask

  task automatic seq_b(input logic [T-1:0] w, input logic [T-1:0] exp_rb);
    logic [6:0] e;
    b_valid = 1'b1;
    b_data  = w;
    chk("b_start_ready", 32'(b_ready), 32'd1);
    @(posedge clk);
    for (int c = 1; c <= T + 2; c++) begin
      @(negedge clk);
      e = {c == T + 2, c != T + 2, c <= T, (c <= T) ? w[(c-1) % T] : 1'b0,
           c == T + 1, 1'b0, c == T + 2};
      chk($sformatf("b_outs_c%0d", c), 32'(outs_b()), 32'(e));
      if (c == 1) b_valid = 1'b0;
    end
    chk("b_rb_data", 32'(b_rb), 32'(exp_rb));
    chk("b_active", 32'(active_b), 32'(w));
    $display("seq B word=%h rb=%h active=%h", w, b_rb, active_b);
  endtask

  initial begin
    logic [T-1:0] snap_active, last_word, w;
    int           snap_lat;

    tbl[0] = '{16'hA5C3, 16'h1234, 16'hA5C3};
    tbl[1] = '{16'h3C5A, 16'hA5C3, 16'h3C5A};
    tbl[2] = '{16'h0001, 16'h3C5A, 16'h0001};
    tbl[3] = '{16'h8000, 16'h0001, 16'h8000};

    rst = 1'b1; pre = 1'b1; pre_val = 16'h1234;
    a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("a_reset_outs", 32'(outs_a()), 32'(7'b1000000));
    chk("a_reset_rb",   32'(a_rb), 32'h0);
    chk("b_reset_outs", 32'(outs_b()), 32'(7'b1000000));
    chk("b_reset_rb",   32'(b_rb), 32'h0);
    rst = 1'b0; pre = 1'b0;
    @(negedge clk);

    // CLR_CYCLES=0 instance: done right after latch, no clear.
    seq_b(16'h0F0F, 16'h1234);
    seq_b(16'hF0F0, 16'h0F0F);

    // Table-driven single sequences on A.
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_data  = tbl[i].data;
      seq_a(tbl[i].data, tbl[i].exp_rb, 1'b0, '0, 1'b0);
      chk($sformatf("tbl%0d_active", i), 32'(active_a), 32'(tbl[i].exp_active));
    end

    // Back-to-back: valid held through done, second word taken on the done cycle.
    a_valid = 1'b1;
    a_data  = 16'h00FF;
    seq_a(16'h00FF, 16'h8000, 1'b1, 16'hFF00, 1'b0);
    seq_a(16'hFF00, 16'h00FF, 1'b0, '0, 1'b0);

    // Handshake hygiene: a stray valid during SHIFT is ignored, only one done.
    a_valid = 1'b1;
    a_data  = 16'h5A5A;
    seq_a(16'h5A5A, 16'hFF00, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("hyg_single_done", 32'(outs_a()), 32'(7'b1000000));

    // Reset after 7 shift cycles: abort, no latch, readback cleared.
    snap_active = active_a;
    snap_lat    = a_latch_cnt;
    a_valid = 1'b1;
    a_data  = 16'hC0DE;
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("abort_sc_en", 32'(a_sc_en), 32'd1);
      a_valid = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_outs", 32'(outs_a()), 32'(7'b1000000));
    chk("abort_rb",   32'(a_rb), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", 32'(outs_a()), 32'(7'b1000000));
    chk("abort_active", 32'(active_a), 32'(snap_active));
    chk("abort_no_latch", 32'(a_latch_cnt), 32'(snap_lat));
    $display("abort A active=%h rb=%h", active_a, a_rb);

    // Randomized sequences: readback must equal whatever the chain held beforehand,
    // which after a completed sequence is the word previously programmed.
    last_word = chain_a;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("rand_idle", 32'(outs_a()), 32'(7'b1000000));
      end
      w = T'($urandom);
      a_valid = 1'b1;
      a_data  = w;
      seq_a(w, last_word, 1'b0, '0, ($urandom_range(0, 3) == 0));
      last_word = w;
    end

    @(negedge clk);
    chk("b_never_clr", 32'(b_clr_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
